// File: rtl/crc_pkg.sv
// Shared CRC helpers: bit-serial step applied across a whole beat, bit reversal,
// and common polynomial presets. Everything works on 64-bit containers and takes
// the active widths as arguments, so one function serves every instance.
package crc_pkg;

   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
   localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

   // All-ones mask covering the low w bits (w = 1..64).
   function automatic logic [63:0] width_mask(input int w);
      logic [63:0] m;
      if (w >= 64) m = '1;
      else         m = (64'd1 << w) - 64'd1;
      return m;
   endfunction

   // Reverse the low w bits of v; bits above w come back as zero.
   function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int w);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 64; k++) begin
         if (k < w) r[k] = v[w-1-k];
      end
      return r;
   endfunction

   // Feed data_w bits of d into register r, one LFSR step per bit.
   // reflect_in selects LSB-first consumption instead of MSB-first.
   function automatic logic [63:0] crc_step(input logic [63:0] r_in,
                                            input logic [63:0] d,
                                            input int          crc_w,
                                            input logic [63:0] poly,
                                            input int          data_w,
                                            input logic        reflect_in);
      logic [63:0] r;
      logic [63:0] mask;
      logic        b;
      logic        fb;
      mask = width_mask(crc_w);
      r    = r_in & mask;
      for (int k = 0; k < 64; k++) begin
         if (k < data_w) begin
            b  = reflect_in ? d[k] : d[data_w-1-k];
            fb = r[crc_w-1] ^ b;
            r  = (r << 1) & mask;
            if (fb) r = r ^ (poly & mask);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_engine.sv
// Framed CRC engine: consumes DATA_W bits per enabled beat, publishes the final
// CRC with a one-cycle valid strobe after the beat flagged `last`, checks the raw
// final register against RESIDUE, and counts accepted beats per frame.
module crc_engine
   import crc_pkg::*;
#(
   parameter int                 CRC_W       = 16,
   parameter logic [CRC_W-1:0]   POLY        = 16'h1021,
   parameter logic [CRC_W-1:0]   INIT        = 16'hFFFF,
   parameter logic [CRC_W-1:0]   XOR_OUT     = 16'h0000,
   parameter logic [CRC_W-1:0]   RESIDUE     = 16'h0000,
   parameter int                 DATA_W      = 8,
   parameter bit                 REFLECT_IN  = 1'b0,
   parameter bit                 REFLECT_OUT = 1'b0,
   parameter int                 CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              init,
   input  logic [DATA_W-1:0] data_in,
   input  logic              last,
   output logic [CRC_W-1:0]  crc_state,
   output logic [CRC_W-1:0]  crc_out,
   output logic              crc_valid,
   output logic              match,
   output logic [CNT_W-1:0]  beat_cnt
);

   localparam logic [63:0] POLY_EXT = 64'(POLY);

   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] crc_next;
   logic [CRC_W-1:0] crc_out_reg;
   logic [CRC_W-1:0] crc_out_next;
   logic             crc_valid_reg;
   logic             match_reg;
   logic [CNT_W-1:0] beat_cnt_reg;
   logic [CNT_W-1:0] beat_cnt_next;

   logic [63:0]      seed_ext;
   logic [63:0]      data_ext;
   logic [63:0]      step_ext;
   logic [63:0]      rev_ext;

   // Next raw register for this beat; an init in the same cycle restarts from INIT.
   always_comb begin
      seed_ext                 = '0;
      seed_ext[CRC_W-1:0]      = init ? INIT : crc_reg;
      data_ext                 = '0;
      data_ext[DATA_W-1:0]     = data_in;
      step_ext                 = crc_step(seed_ext, data_ext, CRC_W, POLY_EXT, DATA_W, REFLECT_IN);
      crc_next                 = step_ext[CRC_W-1:0];
      rev_ext                  = bit_reverse(step_ext, CRC_W);
      crc_out_next             = (REFLECT_OUT ? rev_ext[CRC_W-1:0] : crc_next) ^ XOR_OUT;
   end

   // Beat counter increment, restarting at 1 on init and holding at all-ones.
   always_comb begin
      if (init)                     beat_cnt_next = CNT_W'(1);
      else if (beat_cnt_reg == '1)  beat_cnt_next = beat_cnt_reg;
      else                          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
   end

   // Frame control: reset > init > enable; a last beat publishes and rearms.
   always_ff @(posedge clk) begin
      if (reset) begin
         crc_reg       <= INIT;
         beat_cnt_reg  <= '0;
         crc_out_reg   <= '0;
         crc_valid_reg <= 1'b0;
         match_reg     <= 1'b0;
      end else begin
         crc_valid_reg <= 1'b0;
         if (enable) begin
            if (last) begin
               crc_out_reg   <= crc_out_next;
               match_reg     <= (crc_next == RESIDUE);
               crc_valid_reg <= 1'b1;
               crc_reg       <= INIT;
               beat_cnt_reg  <= '0;
            end else begin
               crc_reg       <= crc_next;
               beat_cnt_reg  <= beat_cnt_next;
            end
         end else if (init) begin
            crc_reg      <= INIT;
            beat_cnt_reg <= '0;
         end
      end
   end

   assign crc_state = crc_reg;
   assign crc_out   = crc_out_reg;
   assign crc_valid = crc_valid_reg;
   assign match     = match_reg;
   assign beat_cnt  = beat_cnt_reg;

endmodule
